io_port_responder: RTL and testbench
====================================

Name: io_port_responder

Overview:
Peripheral-side endpoint of the IO command link driven by the command controller. It accepts one request per REQ/ACK transfer, which is either a data write or a port command. It applies the request to a GPIO port made of an output register, an output-enable register and synchronized input pins. When the request asks for a response, it returns one response word with a destination register over a separate REQ/ACK response channel.

Parameters:
DATABITWIDTH, 16, width of request/response data words
PORTWIDTH, 8, number of GPIO pins; must be <= DATABITWIDTH-3
OPCODE_MSB, 15, MSB of 3-bit command opcode field in request data (opcode = data[OPCODE_MSB:OPCODE_MSB-2])

Ports:
sys_clk  in  1  system clock, all logic on rising edge
async_rst_n  in  1  asynchronous active-low reset
clk_en  in  1  global clock enable; low freezes FSM and port registers
IOREQ  in  1  request valid from controller
IOACK  out  1  responder ready; transfer when IOREQ && IOACK at rising edge
IOCommandEn  in  1  1 = port command, 0 = data write
IOResponseRequested  in  1  1 = return a response for this request
ReqDestReg  in  4  destination register tag to echo in response
ReqData  in  DATABITWIDTH  request data / command word
RespREQ  out  1  response valid
RespACK  in  1  controller accepts response; transfer when RespREQ && RespACK
RespCommandFlag  out  1  echo of captured IOCommandEn
RespRegFlag  out  1  response targets register file; always 1 when RespREQ
RespMemFlag  out  1  always 0
RespDestReg  out  4  captured ReqDestReg
RespData  out  DATABITWIDTH  response word
PinsIn  in  PORTWIDTH  asynchronous input pins
PinsOut  out  PORTWIDTH  output register
PinsOE  out  PORTWIDTH  output-enable register

Behaviour:
- Reset (async_rst_n low, immediate): state IDLE, IOACK=0, RespREQ=0, RespCommandFlag/RespRegFlag/RespMemFlag=0, RespDestReg=0, RespData=0, PinsOut=0, PinsOE=0, both synchronizer stages=0. Reset mid-request or mid-response drops that request or response silently.
- Input sync: 2-flop synchronizer on PinsIn. It runs regardless of clk_en. A pin change before edge k is visible in the synced value after edge k+1.
- FSM states IDLE, EXEC, RESP. The registered IOACK is 1 only in IDLE. Output IOACK = registered IOACK && clk_en.
- IDLE: on IOREQ && IOACK, capture CommandEn, ResponseRequested, ReqDestReg and ReqData, then go to EXEC. IOACK drops on the next cycle, so at most one transfer is taken per request.
- EXEC (1 cycle): apply operation, form RespData. Go to RESP with RespREQ=1 if ResponseRequested, else go to IDLE.
- RESP: hold all Resp* outputs stable until RespREQ && RespACK, then RespREQ=0 and go to IDLE. No new request is accepted while in RESP.
- Latency: accept at edge N gives register updates and RespREQ visible after edge N+1. Earliest next accept is edge N+2 when no response is requested. When a response is requested, it is the edge after RespACK.
- mask = ReqData[PORTWIDTH-1:0]. RespData is zero-extended to DATABITWIDTH.
- Data write (CommandEn=0): PinsOut <= mask. RespData = new PinsOut.
- Commands, by opcode:
  - 0 READ_IN: RespData = synced pins, as sampled in the EXEC cycle.
  - 1 WRITE_OE: PinsOE <= mask. RespData = new PinsOE.
  - 2 READ_OUT: RespData = PinsOut.
  - 3 SET: PinsOut |= mask.
  - 4 CLR: PinsOut &= ~mask.
  - 5 TOG: PinsOut ^= mask.
  - Opcodes 3/4/5 return RespData = new PinsOut.
  - 6 READ_OE: RespData = PinsOE.
  - 7 reserved: no state change. RespData = all ones (error marker).
- Data bits between PORTWIDTH and the opcode field are ignored.
- clk_en low: FSM, captured fields, PinsOut, PinsOE and Resp* hold their values. IOACK reads 0. A pending RespREQ stays high, but RespACK is ignored until clk_en returns high.
- IOREQ is ignored outside IDLE. RespACK is ignored when RespREQ=0.

Test Plan:
- Reset then data write with ReqData=16'h00A5, IOResponseRequested=1, ReqDestReg=4'hF -> PinsOut=8'hA5 one cycle after the accept edge. Response has RespData=16'h00A5, RespDestReg=4'hF, RespCommandFlag=0, RespRegFlag=1, RespMemFlag=0.
- After PinsOut=8'hA5, send SET mask 8'h0F, then CLR mask 8'h81, then TOG mask 8'hFF, all with no response -> PinsOut becomes 8'hAF, then 8'h2E, then 8'hD1. No RespREQ is raised. IOACK is high again 2 cycles after each accept.
- Drive PinsIn=8'h3C, then issue READ_IN 3 cycles later with IOResponseRequested=1 and ReqDestReg=4'h7 -> RespData=16'h003C, RespDestReg=4'h7. Changing PinsIn at the same cycle as the accept edge is not reflected in RespData.
- Response backpressure: hold RespACK=0 for 5 cycles while IOREQ stays high with a second request -> RespREQ and Resp* stay stable, IOACK stays 0, and the second request is accepted only after RespACK=1.
- Reserved opcode 7 with a response requested -> RespData=16'hFFFF, and PinsOut/PinsOE are unchanged.
- Pull async_rst_n low while in RESP -> RespREQ=0, PinsOut=0 and PinsOE=0 immediately. After reset release, IOACK=1 from the first clk_en-high cycle.

Source files
------------

// File: rtl/io_port_responder_if.sv
// io_port_responder_if: request and response REQ/ACK channels between the command controller and an IO port responder
interface io_port_responder_if #(
    parameter int DATABITWIDTH = 16
);
    logic                    IOREQ;
    logic                    IOACK;
    logic                    IOCommandEn;
    logic                    IOResponseRequested;
    logic [3:0]              ReqDestReg;
    logic [DATABITWIDTH-1:0] ReqData;
    logic                    RespREQ;
    logic                    RespACK;
    logic                    RespCommandFlag;
    logic                    RespRegFlag;
    logic                    RespMemFlag;
    logic [3:0]              RespDestReg;
    logic [DATABITWIDTH-1:0] RespData;

    modport master (
        output IOREQ, IOCommandEn, IOResponseRequested, ReqDestReg, ReqData, RespACK,
        input  IOACK, RespREQ, RespCommandFlag, RespRegFlag, RespMemFlag, RespDestReg, RespData
    );

    modport slave (
        input  IOREQ, IOCommandEn, IOResponseRequested, ReqDestReg, ReqData, RespACK,
        output IOACK, RespREQ, RespCommandFlag, RespRegFlag, RespMemFlag, RespDestReg, RespData
    );
endinterface

// File: rtl/io_port_responder.sv
// io_port_responder: GPIO port endpoint that executes one link request at a time and optionally returns a response word
module io_port_responder #(
    parameter int DATABITWIDTH = 16,
    parameter int PORTWIDTH    = 8,
    parameter int OPCODE_MSB   = 15
) (
    input  logic                 sys_clk,
    input  logic                 async_rst_n,
    input  logic                 clk_en,
    io_port_responder_if.slave   bus,
    input  logic [PORTWIDTH-1:0] PinsIn,
    output logic [PORTWIDTH-1:0] PinsOut,
    output logic [PORTWIDTH-1:0] PinsOE
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [2:0] OP_READ_IN  = 3'd0;
    localparam logic [2:0] OP_WRITE_OE = 3'd1;
    localparam logic [2:0] OP_READ_OUT = 3'd2;
    localparam logic [2:0] OP_SET      = 3'd3;
    localparam logic [2:0] OP_CLR      = 3'd4;
    localparam logic [2:0] OP_TOG      = 3'd5;
    localparam logic [2:0] OP_READ_OE  = 3'd6;
    localparam logic [2:0] OP_RSVD     = 3'd7;

    logic [1:0]              state;
    logic                    ackReg;
    logic                    capCmd;
    logic                    capResp;
    logic [3:0]              capDest;
    logic [2:0]              capOp;
    logic [PORTWIDTH-1:0]    capMask;
    logic [PORTWIDTH-1:0]    syncA;
    logic [PORTWIDTH-1:0]    syncB;
    logic [PORTWIDTH-1:0]    nextOut;
    logic [PORTWIDTH-1:0]    nextOE;
    logic [PORTWIDTH-1:0]    respPort;
    logic [DATABITWIDTH-1:0] respWord;

    assign bus.IOACK       = ackReg && clk_en;
    assign bus.RespMemFlag = 1'b0;

    // Two-flop input synchronizer, free-running so pins stay fresh while the core is frozen
    always_ff @(posedge sys_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            syncA <= '0;
            syncB <= '0;
        end else begin
            syncA <= PinsIn;
            syncB <= syncA;
        end
    end

    // Result of the captured request: new port registers and the response word
    always_comb begin
        nextOut  = !capCmd ? capMask :
                   capOp == OP_SET ? (PinsOut | capMask) :
                   capOp == OP_CLR ? (PinsOut & ~capMask) :
                   capOp == OP_TOG ? (PinsOut ^ capMask) : PinsOut;
        nextOE   = (capCmd && capOp == OP_WRITE_OE) ? capMask : PinsOE;
        respPort = !capCmd ? nextOut :
                   capOp == OP_READ_IN  ? syncB :
                   capOp == OP_WRITE_OE ? nextOE :
                   capOp == OP_READ_OUT ? PinsOut :
                   capOp == OP_READ_OE  ? PinsOE : nextOut;
        respWord = (capCmd && capOp == OP_RSVD) ? '1 : DATABITWIDTH'(respPort);
    end

    // Request FSM: accept in IDLE, apply in EXEC, hold the response in RESP until acknowledged
    always_ff @(posedge sys_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state               <= IDLE;
            ackReg              <= 1'b0;
            capCmd              <= 1'b0;
            capResp             <= 1'b0;
            capDest             <= '0;
            capOp               <= '0;
            capMask             <= '0;
            PinsOut             <= '0;
            PinsOE              <= '0;
            bus.RespREQ         <= 1'b0;
            bus.RespCommandFlag <= 1'b0;
            bus.RespRegFlag     <= 1'b0;
            bus.RespDestReg     <= '0;
            bus.RespData        <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (bus.IOREQ && ackReg) begin
                        capCmd  <= bus.IOCommandEn;
                        capResp <= bus.IOResponseRequested;
                        capDest <= bus.ReqDestReg;
                        capOp   <= bus.ReqData[OPCODE_MSB -: 3];
                        capMask <= bus.ReqData[PORTWIDTH-1:0];
                        state   <= EXEC;
                        ackReg  <= 1'b0;
                    end else begin
                        ackReg <= 1'b1;
                    end
                end
                EXEC: begin
                    PinsOut <= nextOut;
                    PinsOE  <= nextOE;
                    if (capResp) begin
                        state               <= RESP;
                        bus.RespREQ         <= 1'b1;
                        bus.RespCommandFlag <= capCmd;
                        bus.RespRegFlag     <= 1'b1;
                        bus.RespDestReg     <= capDest;
                        bus.RespData        <= respWord;
                    end else begin
                        state  <= IDLE;
                        ackReg <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.RespACK) begin
                        bus.RespREQ <= 1'b0;
                        state       <= IDLE;
                        ackReg      <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    ackReg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder: directed and randomized checks of io_port_responder against a GPIO port model
module tb_io_port_responder;
    logic       sys_clk     = 1'b0;
    logic       async_rst_n = 1'b0;
    logic       clk_en      = 1'b1;
    logic [7:0] PinsIn      = 8'h00;
    logic [7:0] PinsOut;
    logic [7:0] PinsOE;

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] mOut  = 8'h00;
    logic [7:0] mOE   = 8'h00;
    logic [7:0] mPins = 8'h00;

    io_port_responder_if #(.DATABITWIDTH(16)) bus ();

    io_port_responder #(.DATABITWIDTH(16), .PORTWIDTH(8), .OPCODE_MSB(15)) dut (
        .sys_clk(sys_clk),
        .async_rst_n(async_rst_n),
        .clk_en(clk_en),
        .bus(bus),
        .PinsIn(PinsIn),
        .PinsOut(PinsOut),
        .PinsOE(PinsOE)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Port behaviour from the operation table: new PinsOut, new PinsOE and the response word
    function automatic void model(input logic cmd, input logic [15:0] d,
                                  output logic [7:0] nOut, output logic [7:0] nOE, output logic [15:0] r);
        logic [7:0] m;
        m    = d[7:0];
        nOut = mOut;
        nOE  = mOE;
        r    = 16'hFFFF;
        if (!cmd) begin
            nOut = m;
            r    = {8'h00, m};
        end else begin
            case (d[15:13])
                3'd0: r = {8'h00, mPins};
                3'd1: begin nOE = m; r = {8'h00, m}; end
                3'd2: r = {8'h00, mOut};
                3'd3: begin nOut = mOut | m; r = {8'h00, nOut}; end
                3'd4: begin nOut = mOut & ~m; r = {8'h00, nOut}; end
                3'd5: begin nOut = mOut ^ m; r = {8'h00, nOut}; end
                3'd6: r = {8'h00, mOE};
                default: r = 16'hFFFF;
            endcase
        end
    endfunction

    task automatic acceptReq(input logic cmd, input logic rr, input logic [3:0] dest,
                             input logic [15:0] d, input bit hold);
        int n = 0;
        bus.IOCommandEn         = cmd;
        bus.IOResponseRequested = rr;
        bus.ReqDestReg          = dest;
        bus.ReqData             = d;
        bus.IOREQ               = 1'b1;
        while (!bus.IOACK && n < 20) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        checkVal("ackWait", bus.IOACK, 1);
        @(posedge sys_clk);
        #1;
        if (!hold) bus.IOREQ = 1'b0;
        checkVal("ackDrop", bus.IOACK, 0);
    endtask

    task automatic checkResp(input logic cmd, input logic [3:0] dest, input logic [15:0] r);
        checkVal("respData", bus.RespData, r);
        checkVal("respDest", bus.RespDestReg, dest);
        checkVal("respCmdFlag", bus.RespCommandFlag, cmd);
        checkVal("respRegFlag", bus.RespRegFlag, 1);
        checkVal("respMemFlag", bus.RespMemFlag, 0);
    endtask

    task automatic doReq(input logic cmd, input logic rr, input logic [3:0] dest, input logic [15:0] d,
                         input int ackDelay, input bit chg, input logic [7:0] np);
        logic [7:0]  nOut;
        logic [7:0]  nOE;
        logic [15:0] r;
        model(cmd, d, nOut, nOE, r);
        acceptReq(cmd, rr, dest, d, 1'b0);
        if (chg) PinsIn = np;
        @(posedge sys_clk);
        #1;
        checkVal("pinsOut", PinsOut, nOut);
        checkVal("pinsOE", PinsOE, nOE);
        checkVal("respReq", bus.RespREQ, rr);
        mOut = nOut;
        mOE  = nOE;
        if (rr) begin
            checkResp(cmd, dest, r);
            for (int k = 0; k < ackDelay; k++) begin
                @(posedge sys_clk);
                #1;
                checkVal("holdReq", bus.RespREQ, 1);
                checkVal("holdData", bus.RespData, r);
                checkVal("holdAck", bus.IOACK, 0);
            end
            bus.RespACK = 1'b1;
            @(posedge sys_clk);
            #1;
            bus.RespACK = 1'b0;
            checkVal("respDone", bus.RespREQ, 0);
        end
        checkVal("ackBack", bus.IOACK, 1);
    endtask

    initial begin
        bus.IOREQ               = 1'b0;
        bus.IOCommandEn         = 1'b0;
        bus.IOResponseRequested = 1'b0;
        bus.ReqDestReg          = 4'h0;
        bus.ReqData             = 16'h0000;
        bus.RespACK             = 1'b0;
        #3;
        checkVal("rstAck", bus.IOACK, 0);
        checkVal("rstRespReq", bus.RespREQ, 0);
        checkVal("rstRespData", bus.RespData, 0);
        checkVal("rstRespDest", bus.RespDestReg, 0);
        checkVal("rstFlags", {bus.RespCommandFlag, bus.RespRegFlag, bus.RespMemFlag}, 0);
        checkVal("rstPinsOut", PinsOut, 0);
        checkVal("rstPinsOE", PinsOE, 0);
        #9 async_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        checkVal("ackAfterRst", bus.IOACK, 1);

        doReq(1'b0, 1'b1, 4'hF, 16'h00A5, 2, 1'b0, 8'h00);
        doReq(1'b1, 1'b0, 4'h0, 16'h600F, 0, 1'b0, 8'h00);
        checkVal("setOut", PinsOut, 8'hAF);
        doReq(1'b1, 1'b0, 4'h0, 16'h8081, 0, 1'b0, 8'h00);
        checkVal("clrOut", PinsOut, 8'h2E);
        doReq(1'b1, 1'b0, 4'h0, 16'hA0FF, 0, 1'b0, 8'h00);
        checkVal("togOut", PinsOut, 8'hD1);

        PinsIn = 8'h3C;
        mPins  = 8'h3C;
        repeat (3) @(posedge sys_clk);
        #1;
        doReq(1'b1, 1'b1, 4'h7, 16'h0000, 1, 1'b1, 8'hC3);
        mPins = 8'hC3;
        repeat (3) @(posedge sys_clk);
        #1;

        doReq(1'b1, 1'b0, 4'h0, 16'h2055, 0, 1'b0, 8'h00);
        doReq(1'b1, 1'b1, 4'h4, 16'hE1FF, 0, 1'b0, 8'h00);
        checkVal("rsvdOut", PinsOut, 8'hD1);
        checkVal("rsvdOE", PinsOE, 8'h55);

        acceptReq(1'b0, 1'b1, 4'h3, 16'h0033, 1'b1);
        bus.IOResponseRequested = 1'b0;
        bus.ReqDestReg          = 4'h0;
        bus.ReqData             = 16'h005A;
        @(posedge sys_clk);
        #1;
        checkVal("bpReq", bus.RespREQ, 1);
        checkVal("bpOut", PinsOut, 8'h33);
        repeat (5) begin
            @(posedge sys_clk);
            #1;
            checkVal("bpHoldReq", bus.RespREQ, 1);
            checkVal("bpHoldData", bus.RespData, 16'h0033);
            checkVal("bpHoldDest", bus.RespDestReg, 4'h3);
            checkVal("bpHoldAck", bus.IOACK, 0);
            checkVal("bpHoldOut", PinsOut, 8'h33);
        end
        bus.RespACK = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.RespACK = 1'b0;
        checkVal("bpDone", bus.RespREQ, 0);
        checkVal("bpAckBack", bus.IOACK, 1);
        @(posedge sys_clk);
        #1;
        bus.IOREQ = 1'b0;
        checkVal("bpSecondTaken", bus.IOACK, 0);
        @(posedge sys_clk);
        #1;
        checkVal("bpSecondOut", PinsOut, 8'h5A);
        checkVal("bpSecondNoResp", bus.RespREQ, 0);
        mOut = 8'h5A;

        acceptReq(1'b1, 1'b1, 4'h2, 16'h4000, 1'b0);
        @(posedge sys_clk);
        #1;
        checkVal("ceReq", bus.RespREQ, 1);
        checkVal("ceData", bus.RespData, {8'h00, mOut});
        clk_en      = 1'b0;
        bus.RespACK = 1'b1;
        repeat (3) begin
            @(posedge sys_clk);
            #1;
            checkVal("ceHoldReq", bus.RespREQ, 1);
            checkVal("ceHoldAck", bus.IOACK, 0);
        end
        clk_en = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.RespACK = 1'b0;
        checkVal("ceDone", bus.RespREQ, 0);
        checkVal("ceAckBack", bus.IOACK, 1);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                PinsIn = 8'($urandom);
                mPins  = PinsIn;
                repeat (3) @(posedge sys_clk);
                #1;
            end
            doReq(1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom),
                  int'($urandom_range(0, 3)), 1'b0, 8'h00);
        end

        doReq(1'b1, 1'b0, 4'h0, 16'h20F0, 0, 1'b0, 8'h00);
        acceptReq(1'b0, 1'b1, 4'h9, 16'h00C3, 1'b0);
        @(posedge sys_clk);
        #1;
        checkVal("rrReq", bus.RespREQ, 1);
        #2 async_rst_n = 1'b0;
        #1;
        checkVal("rrRespReq", bus.RespREQ, 0);
        checkVal("rrPinsOut", PinsOut, 0);
        checkVal("rrPinsOE", PinsOE, 0);
        checkVal("rrAck", bus.IOACK, 0);
        repeat (2) @(posedge sys_clk);
        #1 async_rst_n = 1'b1;
        mOut = 8'h00;
        mOE  = 8'h00;
        @(posedge sys_clk);
        #1;
        checkVal("rrAckAfter", bus.IOACK, 1);
        repeat (3) @(posedge sys_clk);
        #1;
        doReq(1'b1, 1'b1, 4'h1, 16'h0000, 0, 1'b0, 8'h00);
        doReq(1'b1, 1'b1, 4'h1, 16'hC000, 0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
